// File: rtl/fft_pkg.sv
// Shared constants, types and FSM state encoding for the FFT peak detector.
// Optional threshold counting in the top level is enabled by FFT_PEAK_THRESH_EN.
package fft_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int ADDR_WIDTH  = 8;
  localparam int FFT_SIZE    = 2 ** ADDR_WIDTH;
  localparam int SEARCH_BINS = 128;
  localparam int PWR_WIDTH   = 2 * DATA_WIDTH;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic [ADDR_WIDTH-1:0]        bin_t;
  typedef logic [PWR_WIDTH-1:0]         pwr_t;
  typedef logic [ADDR_WIDTH:0]          count_t;

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, REPORT} peak_state_t;

  // Only the positive-frequency half of the spectrum competes for the peak.
  function automatic logic in_search(input bin_t bin);
    return int'(bin) < SEARCH_BINS;
  endfunction

endpackage

// File: rtl/fft_peak_detect_if.sv
// Addressed FFT output stream (real, imag, addr, valid) feeding the peak detector.
interface fft_peak_detect_if;
  import fft_pkg::*;

  sample_t in_real;
  sample_t in_imag;
  bin_t    in_addr;
  logic    in_valid;

  modport master (output in_real, in_imag, in_addr, in_valid);
  modport slave  (input  in_real, in_imag, in_addr, in_valid);

endinterface

// File: rtl/fft_power_calc.sv
// Power pipeline: registered squares with addr/valid alongside, then the sum
// of squares presented combinationally to the compare stage.
module fft_power_calc
  import fft_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  sample_t in_real,
  input  sample_t in_imag,
  input  bin_t    in_addr,
  input  logic    in_valid,
  output pwr_t    pwr,
  output bin_t    pwr_addr,
  output logic    pwr_valid
);

  logic signed [PWR_WIDTH-1:0] re_ext;
  logic signed [PWR_WIDTH-1:0] im_ext;
  pwr_t re_sq;
  pwr_t im_sq;

  assign re_ext = PWR_WIDTH'(in_real);
  assign im_ext = PWR_WIDTH'(in_imag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_sq     <= '0;
      im_sq     <= '0;
      pwr_addr  <= '0;
      pwr_valid <= 1'b0;
    end else begin
      re_sq     <= $unsigned(re_ext * re_ext);
      im_sq     <= $unsigned(im_ext * im_ext);
      pwr_addr  <= in_addr;
      pwr_valid <= in_valid;
    end
  end

  // Each square is at most 2^30, so the unsigned sum never exceeds 2^31.
  assign pwr = re_sq + im_sq;

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak-power bin detector downstream of the 256-point FFT.
// Define FFT_PEAK_THRESH_EN to add thr_power / above_count threshold counting.
module fft_peak_detect
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  fft_peak_detect_if.slave    s_in,
`ifdef FFT_PEAK_THRESH_EN
  input  pwr_t                thr_power,
  output logic [ADDR_WIDTH:0] above_count,
`endif
  output bin_t                peak_bin,
  output pwr_t                peak_power,
  output logic                peak_valid,
  output logic                busy,
  output logic                err_overrun
);

  peak_state_t state;
  count_t      beat_cnt;
  bin_t        best_bin;
  pwr_t        best_pwr;
  pwr_t        pwr;
  bin_t        pwr_addr;
  logic        pwr_valid;
  logic        accept;
  logic        frame_start;
  logic        better;

  // Beats arriving while draining or reporting are dropped before the pipeline.
  assign accept      = s_in.in_valid && (state == IDLE || state == COLLECT);
  assign frame_start = s_in.in_valid && (state == IDLE);
  assign better      = pwr_valid && in_search(pwr_addr) &&
                       (pwr > best_pwr || (pwr == best_pwr && pwr_addr < best_bin));

  fft_power_calc u_power (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_real   (s_in.in_real),
    .in_imag   (s_in.in_imag),
    .in_addr   (s_in.in_addr),
    .in_valid  (accept),
    .pwr       (pwr),
    .pwr_addr  (pwr_addr),
    .pwr_valid (pwr_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      busy        <= 1'b0;
      peak_bin    <= '0;
      peak_power  <= '0;
      peak_valid  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      if (s_in.in_valid && (state == FLUSH || state == REPORT))
        err_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (s_in.in_valid) begin
            state    <= COLLECT;
            beat_cnt <= count_t'(1);
            busy     <= 1'b1;
          end
        end
        COLLECT: begin
          if (s_in.in_valid) begin
            if (int'(beat_cnt) == FFT_SIZE - 1) begin
              state    <= FLUSH;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + count_t'(1);
            end
          end
        end
        // beat_cnt is reused to time the two drain cycles.
        FLUSH: begin
          if (beat_cnt == count_t'(1)) begin
            state    <= REPORT;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= count_t'(1);
          end
        end
        REPORT: begin
          state      <= IDLE;
          busy       <= 1'b0;
          peak_bin   <= best_bin;
          peak_power <= best_pwr;
          peak_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_bin <= '0;
      best_pwr <= '0;
    end else if (frame_start) begin
      best_bin <= '0;
      best_pwr <= '0;
    end else if (better) begin
      best_bin <= pwr_addr;
      best_pwr <= pwr;
    end
  end

`ifdef FFT_PEAK_THRESH_EN
  pwr_t                thr_reg;
  logic [ADDR_WIDTH:0] above_cnt;

  // Threshold is frozen for the whole frame at the first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_reg     <= '0;
      above_cnt   <= '0;
      above_count <= '0;
    end else begin
      if (frame_start) begin
        thr_reg   <= thr_power;
        above_cnt <= '0;
      end else if (pwr_valid && in_search(pwr_addr) && pwr > thr_reg) begin
        above_cnt <= above_cnt + 1'b1;
      end
      if (state == REPORT)
        above_count <= above_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: frame stimulus with a queue of
// expected reports computed by a reference model of the peak search.
module tb_fft_peak_detect;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fft_peak_detect_if bus ();

  bin_t peak_bin;
  pwr_t peak_power;
  logic peak_valid;
  logic busy;
  logic err_overrun;
`ifdef FFT_PEAK_THRESH_EN
  pwr_t                thr_power;
  logic [ADDR_WIDTH:0] above_count;
`endif

  fft_peak_detect dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_in        (bus),
`ifdef FFT_PEAK_THRESH_EN
    .thr_power   (thr_power),
    .above_count (above_count),
`endif
    .peak_bin    (peak_bin),
    .peak_power  (peak_power),
    .peak_valid  (peak_valid),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  typedef struct {
    bin_t bin;
    pwr_t pwr;
    int   above;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total = 0;
  int   fr_re[FFT_SIZE];
  int   fr_im[FFT_SIZE];
  int   fr_addr[FFT_SIZE];
  int   thr_val = 0;
  int   pulses = 0;

  always @(negedge clk) if (peak_valid === 1'b1) pulses++;

  task automatic clear_frame();
    for (int i = 0; i < FFT_SIZE; i++) begin
      fr_re[i]   = 0;
      fr_im[i]   = 0;
      fr_addr[i] = i;
    end
  endtask

  // Waits for the report after the last beat; optionally injects one overrun beat.
  task automatic wait_report(input string tag, input bit extra);
    int   first_k;
    exp_t e;
    first_k = 0;
    for (int k = 1; k <= 12 && first_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.in_valid = extra;
        bus.in_addr  = '0;
        bus.in_real  = 16'sd32767;
        bus.in_imag  = 16'sd32767;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (k == 3) begin
        total++;
        if (busy !== 1'b1) $display("[TB] FAIL %s busy_report: got %b expected 1", tag, busy);
        else passed++;
      end
      if (peak_valid === 1'b1) first_k = k;
    end
    e = exp_q.pop_front();
    total++;
    if (first_k != 4) $display("[TB] FAIL %s report_latency: got %0d expected 4 cycles after last beat", tag, first_k);
    else passed++;
    if (first_k != 0) begin
      total++;
      if (peak_bin !== e.bin) $display("[TB] FAIL %s peak_bin: got %0d expected %0d", tag, peak_bin, e.bin);
      else passed++;
      total++;
      if (peak_power !== e.pwr) $display("[TB] FAIL %s peak_power: got %0d expected %0d", tag, peak_power, e.pwr);
      else passed++;
      total++;
      if (busy !== 1'b0) $display("[TB] FAIL %s busy_idle: got %b expected 0", tag, busy);
      else passed++;
`ifdef FFT_PEAK_THRESH_EN
      total++;
      if (int'(above_count) != e.above) $display("[TB] FAIL %s above_count: got %0d expected %0d", tag, above_count, e.above);
      else passed++;
`endif
      @(negedge clk);
      total++;
      if (peak_valid !== 1'b0) $display("[TB] FAIL %s pulse_width: got %b expected 0", tag, peak_valid);
      else passed++;
    end
  endtask

  // Reference model pushes the expected report, then the frame is streamed.
  task automatic run_frame(input string tag, input bit extra);
    exp_t   e;
    longint p;
    longint bp;
    int     bb;
    bp = 0;
    bb = 0;
    e.above = 0;
    for (int i = 0; i < FFT_SIZE; i++) begin
      p = longint'(fr_re[i]) * fr_re[i] + longint'(fr_im[i]) * fr_im[i];
      if (fr_addr[i] < SEARCH_BINS) begin
        if (p > longint'(thr_val)) e.above++;
        if (p > bp || (p == bp && fr_addr[i] < bb)) begin
          bp = p;
          bb = fr_addr[i];
        end
      end
    end
    e.bin = bin_t'(bb);
    e.pwr = pwr_t'(bp);
    exp_q.push_back(e);
`ifdef FFT_PEAK_THRESH_EN
    thr_power = pwr_t'(thr_val);
`endif
    for (int i = 0; i < FFT_SIZE; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_addr  = bin_t'(fr_addr[i]);
      bus.in_real  = sample_t'(fr_re[i]);
      bus.in_imag  = sample_t'(fr_im[i]);
    end
    wait_report(tag, extra);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_real  = '0;
    bus.in_imag  = '0;
`ifdef FFT_PEAK_THRESH_EN
    thr_power = '0;
`endif
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (peak_bin !== '0) $display("[TB] FAIL reset peak_bin: got %0d expected 0", peak_bin);
    else passed++;
    total++;
    if (peak_power !== '0) $display("[TB] FAIL reset peak_power: got %0d expected 0", peak_power);
    else passed++;
    total++;
    if (peak_valid !== 1'b0) $display("[TB] FAIL reset peak_valid: got %b expected 0", peak_valid);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("[TB] FAIL reset busy: got %b expected 0", busy);
    else passed++;
    total++;
    if (err_overrun !== 1'b0) $display("[TB] FAIL reset err_overrun: got %b expected 0", err_overrun);
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_bin();
    clear_frame();
    fr_re[10] = 1000;
    run_frame("single_bin", 1'b0);
  endtask

  task automatic test_no_overflow();
    clear_frame();
    fr_re[5] = -32768;
    fr_im[5] = -32768;
    run_frame("no_overflow", 1'b0);
    total++;
    if (peak_power !== 32'h8000_0000) $display("[TB] FAIL no_overflow max_power: got %h expected 80000000", peak_power);
    else passed++;
  endtask

  task automatic test_tie();
    clear_frame();
    for (int i = 0; i < FFT_SIZE; i++) fr_addr[i] = FFT_SIZE - 1 - i;
    fr_re[FFT_SIZE - 1 - 40] = 300;
    fr_im[FFT_SIZE - 1 - 40] = 400;
    fr_re[FFT_SIZE - 1 - 20] = 300;
    fr_im[FFT_SIZE - 1 - 20] = 400;
    run_frame("tie_low_bin", 1'b0);
  endtask

  task automatic test_out_of_range();
    clear_frame();
    fr_re[200] = 30000;
    fr_re[3]   = 10;
    thr_val    = 99;
    run_frame("out_of_range", 1'b0);
    thr_val    = 0;
    total++;
    if (err_overrun !== 1'b0) $display("[TB] FAIL out_of_range err_overrun: got %b expected 0", err_overrun);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    int p0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_addr  = bin_t'(i);
      bus.in_real  = (i == 50) ? 16'sd20000 : 16'sd0;
      bus.in_imag  = '0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("[TB] FAIL midreset busy: got %b expected 0", busy);
    else passed++;
    total++;
    if (peak_power !== '0) $display("[TB] FAIL midreset peak_power: got %0d expected 0", peak_power);
    else passed++;
    rst_n = 1'b1;
    p0 = pulses;
    repeat (20) @(negedge clk);
    total++;
    if (pulses != p0) $display("[TB] FAIL midreset stray_report: got %0d pulses expected 0", pulses - p0);
    else passed++;
    clear_frame();
    fr_im[7] = 50;
    run_frame("after_reset", 1'b0);
    repeat (5) @(negedge clk);
    total++;
    if (pulses != p0 + 1) $display("[TB] FAIL after_reset pulse_count: got %0d expected 1", pulses - p0);
    else passed++;
    clear_frame();
    run_frame("all_zero", 1'b0);
  endtask

  task automatic test_overrun();
    clear_frame();
    fr_re[60] = -500;
    run_frame("overrun", 1'b1);
    total++;
    if (err_overrun !== 1'b1) $display("[TB] FAIL overrun err_set: got %b expected 1", err_overrun);
    else passed++;
  endtask

  task automatic test_back_to_back();
    clear_frame();
    fr_im[100] = 7;
    run_frame("b2b_first", 1'b0);
    clear_frame();
    fr_re[127] = 1;
    fr_im[127] = 1;
    fr_re[128] = 32767;
    run_frame("b2b_edge_bin", 1'b0);
    total++;
    if (err_overrun !== 1'b1) $display("[TB] FAIL b2b err_sticky: got %b expected 1", err_overrun);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_bin();
    test_no_overflow();
    test_tie();
    test_out_of_range();
    test_reset_midframe();
    test_overrun();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
